slave: RTL and testbench
========================

SLAVE -- requirements
Module: slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, meaning the 7-bit bus address it responds to.
REQ-002 The block SHALL have port clk  input  1  system clock; sclk and sda are sampled on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port sclk  input  1  bus clock from the master.
REQ-005 The block SHALL have port sda_in  input  1  bus data from the master's sda_out.
REQ-006 The block SHALL have port sda_out  output  1  bus data to the master's sda_in; 1 means released.
REQ-007 The block SHALL have port data_in  input  8  byte returned on a read; latched at each byte load.
REQ-008 The block SHALL have port data_out  output  8  last byte received on a write.
REQ-009 The block SHALL have port data_valid  output  1  one-clk pulse when data_out updates.
REQ-010 The block SHALL have port rd_strobe  output  1  one-clk pulse when data_in is latched for transmit.
REQ-011 The block SHALL have port state  output  3  current FSM state.

Function
REQ-012 The block SHALL register sclk and sda_in once and derive the following from the current and previous samples: sclk_rise, sclk_fall, START (sda 1->0 while sclk high both samples), STOP (sda 0->1 while sclk high both samples).
REQ-013 The FSM SHALL use these states: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_MACK=6.
REQ-014 All bytes SHALL be bit-ordered LSB first; address bits 0..6 SHALL be followed by the R/W bit (1=read), then the ACK slot.
REQ-015 A START in any state, including a repeated START, SHALL clear the bit counter, release sda_out and enter ADDR on the next clk.
REQ-016 A STOP in any state SHALL release sda_out and enter IDLE; START/STOP SHALL take priority over sclk edges in the same clk.
REQ-017 ADDR: the block SHALL shift in sda on each sclk_rise; after the 8th bit, an address match SHALL drive sda_out=0 at the next sclk_fall and enter ADDR_ACK; a mismatch SHALL enter IDLE with sda_out held 1.
REQ-018 ADDR_ACK: at the following sclk_fall the block SHALL take one of two paths.
  - R/W=1: latch data_in, pulse rd_strobe, drive bit0 and enter TX.
  - R/W=0: release sda_out and enter RX.
REQ-019 RX: the block SHALL shift on sclk_rise; after the 8th bit it SHALL load data_out and pulse data_valid in the same clk, drive ACK at the next sclk_fall, and enter RX_ACK.
REQ-020 RX_ACK: at the next sclk_fall the block SHALL release sda_out and return to RX with counter 0, accepting unlimited bytes.
REQ-021 TX: the block SHALL drive the next bit on each sclk_fall; at the sclk_fall after bit7 it SHALL release sda_out and enter TX_MACK.
REQ-022 TX_MACK: the block SHALL sample sda at sclk_rise.
  - sda=0 (ACK): at the next sclk_fall, relatch data_in, pulse rd_strobe, drive bit0 and enter TX.
  - sda=1 (NACK): enter IDLE.
REQ-023 The bit counter SHALL be 3 bits wide and wrap 7->0 only on a byte boundary; sda_out SHALL change only on sclk_fall, START, STOP or reset.

Reset
REQ-024 On rst, asynchronously, the block SHALL set: state=IDLE, sda_out=1, data_out=8'h00, data_valid=0, rd_strobe=0, counters=0, sample registers=1.
REQ-025 Reset mid-transaction SHALL abandon the transfer; after release the block SHALL ignore bus activity until the next START.

Structure
REQ-026 State encodings, address width and the ACK/NACK constants SHALL live in shared package i2c_pkg, which the master also uses.
REQ-027 Line sampling and START/STOP/edge detection SHALL be sub-module i2c_line_detect; the FSM and shift registers SHALL live in slave.

Verification
REQ-028 The bench SHALL cover a write: START, addr 7'h50, R/W=0, byte 8'hA6, STOP -> ACK low on both ACK slots, data_out=8'hA6, one data_valid pulse, final state IDLE.
REQ-029 The bench SHALL cover a read with NACK: data_in=8'hF6, addr 7'h50, R/W=1 -> sda_out sequence 0,1,1,0,1,1,1,1, one rd_strobe pulse, master NACK -> IDLE.
REQ-030 The bench SHALL cover a two-byte read: data_in 8'h3C then 8'hC3, master ACKs the first byte -> second byte transmitted, two rd_strobe pulses.
REQ-031 The bench SHALL cover an address mismatch: addr 7'h51 -> sda_out stays 1 for the entire transaction, state IDLE after bit 8.
REQ-032 The bench SHALL cover a STOP after bit 3 of RX -> IDLE, no data_valid pulse, data_out unchanged.
REQ-033 The bench SHALL cover rst asserted during TX bit 4 -> immediate sda_out=1 and state IDLE; a new write after release completes correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared bus definitions used by both the master and the slave.
package i2c_pkg;

  localparam int   ADDR_W = 7;
  localparam logic ACK    = 1'b0;  // receiver pulls the line low
  localparam logic NACK   = 1'b1;  // line released; also the idle/released sda level

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_MACK  = 3'd6
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_detect.sv
// Samples the bus lines into the clk domain and flags sclk edges and
// START/STOP conditions from the current and previous samples.
module i2c_line_detect (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sda_in,
  output logic sda,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic start,
  output logic stop
);

  logic sclk_q, sclk_p, sda_q, sda_p;

  // Current and previous samples; an idle bus reads high on both lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 1'b1;
      sclk_p <= 1'b1;
      sda_q  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      sclk_q <= sclk;
      sclk_p <= sclk_q;
      sda_q  <= sda_in;
      sda_p  <= sda_q;
    end
  end

  assign sda       = sda_q;
  assign sclk_rise =  sclk_q & ~sclk_p;
  assign sclk_fall = ~sclk_q &  sclk_p;
  // sda may only move while sclk is high for START/STOP; data changes happen with sclk low
  assign start     = sclk_q & sclk_p &  sda_p & ~sda_q;
  assign stop      = sclk_q & sclk_p & ~sda_p &  sda_q;

endmodule

// File: rtl/slave.sv
// I2C-style bus slave: address match, unlimited-length writes, and reads with
// master ACK/NACK. All bytes travel LSB first.
module slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       rd_strobe,
  output logic [2:0] state
);

  logic sda, sclk_rise, sclk_fall, start, stop;

  i2c_line_detect u_line (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda      (sda),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state_q, state_nx;
  logic [2:0] cnt_q, cnt_nx;
  logic [7:0] shreg_q, shreg_nx, txb_q, txb_nx, dout_nx, shift_in;
  // full_q: a byte (or master ACK) has been taken and the next sclk_fall acts on it
  logic       full_q, full_nx, rw_q, rw_nx, sda_nx, dv_nx, rs_nx;

  assign state    = state_q;
  assign shift_in = {sda, shreg_q[7:1]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      txb_q      <= '0;
      full_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_out    <= NACK;
      data_out   <= '0;
      data_valid <= 1'b0;
      rd_strobe  <= 1'b0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      shreg_q    <= shreg_nx;
      txb_q      <= txb_nx;
      full_q     <= full_nx;
      rw_q       <= rw_nx;
      sda_out    <= sda_nx;
      data_out   <= dout_nx;
      data_valid <= dv_nx;
      rd_strobe  <= rs_nx;
    end
  end

  // Next-state and datapath updates; START/STOP override any sclk edge.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    shreg_nx = shreg_q;
    txb_nx   = txb_q;
    full_nx  = full_q;
    rw_nx    = rw_q;
    sda_nx   = sda_out;
    dout_nx  = data_out;
    dv_nx    = 1'b0;
    rs_nx    = 1'b0;
    if (start) begin
      state_nx = ADDR;
      cnt_nx   = '0;
      full_nx  = 1'b0;
      sda_nx   = NACK;
    end else if (stop) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      full_nx  = 1'b0;
      sda_nx   = NACK;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (sclk_rise && !full_q) begin
            shreg_nx = shift_in;
            cnt_nx   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_nx = sda;
              if (shift_in[6:0] == SLAVE_ADDR) full_nx  = 1'b1;
              else                             state_nx = IDLE;
            end
          end else if (sclk_fall && full_q) begin
            full_nx  = 1'b0;
            sda_nx   = ACK;
            state_nx = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (sclk_fall) begin
            cnt_nx = '0;
            if (rw_q) begin
              txb_nx   = data_in;
              rs_nx    = 1'b1;
              sda_nx   = data_in[0];
              state_nx = TX;
            end else begin
              sda_nx   = NACK;
              state_nx = RX;
            end
          end
        end
        RX: begin
          if (sclk_rise && !full_q) begin
            shreg_nx = shift_in;
            cnt_nx   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              dout_nx = shift_in;
              dv_nx   = 1'b1;
              full_nx = 1'b1;
            end
          end else if (sclk_fall && full_q) begin
            full_nx  = 1'b0;
            sda_nx   = ACK;
            state_nx = RX_ACK;
          end
        end
        RX_ACK: begin
          if (sclk_fall) begin
            sda_nx   = NACK;
            cnt_nx   = '0;
            state_nx = RX;
          end
        end
        TX: begin
          // cnt_q is the index of the bit currently on the line
          if (sclk_fall) begin
            if (cnt_q == 3'd7) begin
              sda_nx   = NACK;
              cnt_nx   = '0;
              state_nx = TX_MACK;
            end else begin
              cnt_nx = cnt_q + 3'd1;
              sda_nx = txb_q[cnt_q + 3'd1];
            end
          end
        end
        TX_MACK: begin
          if (sclk_rise && !full_q) begin
            if (sda == ACK) full_nx  = 1'b1;
            else            state_nx = IDLE;
          end else if (sclk_fall && full_q) begin
            full_nx  = 1'b0;
            txb_nx   = data_in;
            rs_nx    = 1'b1;
            sda_nx   = data_in[0];
            cnt_nx   = '0;
            state_nx = TX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave.sv
// Bench for slave: bit-banged master, table of single-byte transactions plus
// hand-written sequences for multi-byte reads, early STOP and mid-transfer reset.
module tb_slave;

  localparam int Q = 4;  // clk cycles per sclk phase

  logic       clk = 1'b0;
  logic       rst, sclk, sda_in, sda_out, data_valid, rd_strobe;
  logic [7:0] data_in, data_out;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0, rs_cnt = 0, lo_cnt = 0;

  slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sda_in    (sda_in),
    .sda_out   (sda_out),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .rd_strobe (rd_strobe),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Free-running event counters; tests look at deltas.
  always @(posedge clk) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (rd_strobe)  rs_cnt <= rs_cnt + 1;
    if (!sda_out)   lo_cnt <= lo_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, required completion within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    sda_in = 1'b1; sclk = 1'b1; wc(Q);
    sda_in = 1'b0; wc(Q);
    sclk = 1'b0;
  endtask

  task automatic bus_stop();
    wc(2); sda_in = 1'b0; wc(Q);
    sclk = 1'b1; wc(Q);
    sda_in = 1'b1; wc(Q);
  endtask

  task automatic send_bit(input logic b);
    wc(2); sda_in = b; wc(Q);
    sclk = 1'b1; wc(Q);
    sclk = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wc(2); sda_in = 1'b1; wc(Q);
    sclk = 1'b1; wc(2);
    b = sda_out; wc(Q - 2);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] din;
    logic       exp_ack;
    logic [2:0] exp_st;    // state just after the address ACK slot
    logic [7:0] exp_dout;
    int         exp_dv;
    int         exp_rs;
    logic [7:0] exp_rd;
    logic       quiet;     // sda_out must never go low
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic       b;
    logic [7:0] rd;
    int         dv0, rs0, lo0;

    tbl[0] = '{7'h50, 1'b0, 8'hA6, 8'h00, 1'b0, 3'd3, 8'hA6, 1, 0, 8'h00, 1'b0};
    tbl[1] = '{7'h50, 1'b1, 8'h00, 8'hF6, 1'b0, 3'd5, 8'hA6, 0, 1, 8'hF6, 1'b0};
    tbl[2] = '{7'h51, 1'b0, 8'h77, 8'h00, 1'b1, 3'd0, 8'hA6, 0, 0, 8'h00, 1'b1};
    tbl[3] = '{7'h50, 1'b0, 8'h5A, 8'h00, 1'b0, 3'd3, 8'h5A, 1, 0, 8'h00, 1'b0};
    tbl[4] = '{7'h51, 1'b1, 8'h00, 8'hFF, 1'b1, 3'd0, 8'h5A, 0, 0, 8'h00, 1'b1};
    tbl[5] = '{7'h50, 1'b1, 8'h00, 8'h81, 1'b0, 3'd5, 8'h5A, 0, 1, 8'h81, 1'b0};

    rst = 1'b1; sclk = 1'b1; sda_in = 1'b1; data_in = 8'h00;
    wc(3);
    chk("reset_state", state, 0);
    chk("reset_sda", sda_out, 1);
    chk("reset_dout", data_out, 8'h00);
    chk("reset_dv", data_valid, 0);
    chk("reset_rs", rd_strobe, 0);
    rst = 1'b0;
    wc(3);

    foreach (tbl[r]) begin
      dv0 = dv_cnt; rs0 = rs_cnt; lo0 = lo_cnt;
      data_in = tbl[r].din;
      bus_start();
      for (int i = 0; i < 7; i++) send_bit(tbl[r].addr[i]);
      send_bit(tbl[r].rw);
      recv_bit(b);
      chk($sformatf("row%0d_addr_ack", r), b, tbl[r].exp_ack);
      wc(4);
      chk($sformatf("row%0d_state_after_ack", r), state, tbl[r].exp_st);
      if (!tbl[r].rw) begin
        send_byte(tbl[r].wdata);
        recv_bit(b);
        chk($sformatf("row%0d_data_ack", r), b, tbl[r].exp_ack);
      end else if (!tbl[r].exp_ack) begin
        recv_byte(rd);
        chk($sformatf("row%0d_rd_byte", r), rd, tbl[r].exp_rd);
        send_bit(1'b1);
        wc(4);
        chk($sformatf("row%0d_state_after_nack", r), state, 0);
      end
      bus_stop();
      wc(4);
      chk($sformatf("row%0d_dout", r), data_out, tbl[r].exp_dout);
      chk($sformatf("row%0d_dv_pulses", r), dv_cnt - dv0, tbl[r].exp_dv);
      chk($sformatf("row%0d_rs_pulses", r), rs_cnt - rs0, tbl[r].exp_rs);
      chk($sformatf("row%0d_final_state", r), state, 0);
      if (tbl[r].quiet) chk($sformatf("row%0d_sda_low_clks", r), lo_cnt - lo0, 0);
    end

    // Two-byte read with master ACK between bytes.
    rs0 = rs_cnt;
    data_in = 8'h3C;
    bus_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);      // 7'h50 LSB first
    send_bit(1'b1);                                      // read
    recv_bit(b);
    chk("rd2_addr_ack", b, 0);
    recv_byte(rd);
    chk("rd2_byte0", rd, 8'h3C);
    data_in = 8'hC3;
    send_bit(1'b0);                                      // master ACK
    recv_byte(rd);
    chk("rd2_byte1", rd, 8'hC3);
    send_bit(1'b1);
    bus_stop();
    wc(4);
    chk("rd2_rs_pulses", rs_cnt - rs0, 2);
    chk("rd2_final_state", state, 0);

    // STOP in the middle of a received byte: nothing is delivered.
    dv0 = dv_cnt;
    bus_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);                                      // write
    recv_bit(b);
    chk("early_stop_addr_ack", b, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wc(4);
    chk("early_stop_state_rx", state, 3);
    bus_stop();
    wc(4);
    chk("early_stop_state", state, 0);
    chk("early_stop_dv_pulses", dv_cnt - dv0, 0);
    chk("early_stop_dout", data_out, 8'h5A);

    // Reset while bit 4 of 8'hAA (a 0) is on the line.
    data_in = 8'hAA;
    bus_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1);
    recv_bit(b);
    for (int i = 0; i < 4; i++) recv_bit(b);
    wc(4);
    chk("rst_tx_bit4_low", sda_out, 0);
    chk("rst_tx_state", state, 5);
    rst = 1'b1;
    #1;
    chk("rst_async_sda", sda_out, 1);
    chk("rst_async_state", state, 0);
    wc(2);
    rst = 1'b0;
    wc(2);
    // Address-like traffic without START must be ignored.
    lo0 = lo_cnt;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);
    recv_bit(b);
    chk("post_rst_no_ack", b, 1);
    chk("post_rst_state", state, 0);
    chk("post_rst_sda_low_clks", lo_cnt - lo0, 0);
    bus_stop();

    // Fresh write after reset.
    dv0 = dv_cnt;
    bus_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);
    recv_bit(b);
    chk("wr_after_rst_addr_ack", b, 0);
    send_byte(8'hC5);
    recv_bit(b);
    chk("wr_after_rst_data_ack", b, 0);
    bus_stop();
    wc(4);
    chk("wr_after_rst_dout", data_out, 8'hC5);
    chk("wr_after_rst_dv_pulses", dv_cnt - dv0, 1);
    chk("wr_after_rst_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
